// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: break-before-make round-robin owner of a 4:1 mux select; switch counter under `MUX4_ARB_SWITCH_CNT_EN
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             sel_valid,
  output logic             busy,
  output logic [CNT_W-1:0] switch_count
);
  localparam int HW = MAX_HOLD < 2 ? 1 : $clog2(MAX_HOLD + 1);
  typedef enum logic [1:0] {IDLE, GRANT, SWITCH} state_t;
  state_t state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d, last_q, last_d, w;
  logic [HW-1:0] hold_q, hold_d;
  logic hit, limit;
  always_comb begin
    w = last_q;
    for (int k = 4; k >= 1; k--)
      if (req[2'(last_q + 2'(k))]) w = 2'(last_q + 2'(k));
  end
  assign hit = |req;
  assign limit = MAX_HOLD != 0 && int'(hold_q) >= MAX_HOLD - 1 && (req & ~gnt_q) != 4'b0;
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    sel_d = sel_q;
    last_d = last_q;
    hold_d = hold_q;
    if (state_q == IDLE && hit) begin
      state_d = GRANT;
      gnt_d = 4'b1 << w;
      sel_d = w;
      last_d = w;
      hold_d = '0;
    end else if (state_q == GRANT) begin
      hold_d = hold_q == HW'(MAX_HOLD) ? hold_q : hold_q + HW'(1);
      if ((req & gnt_q) == 4'b0 || limit) begin
        state_d = SWITCH;
        gnt_d = '0;
      end
    end else if (state_q == SWITCH) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      sel_q <= 2'b00;
      last_q <= 2'b11;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      sel_q <= sel_d;
      last_q <= last_d;
      hold_q <= hold_d;
    end
  end
  assign gnt = gnt_q;
  assign sel = sel_q;
  assign sel_valid = |gnt_q;
  assign busy = state_q != IDLE;
`ifdef MUX4_ARB_SWITCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = state_q == IDLE && hit && w != sel_q && ~&cnt_q ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign switch_count = cnt_q;
`else
  assign switch_count = '0;
`endif
endmodule
